// File: rtl/dsp48a1_mac_sequencer_if.sv
// Job, operand and result streams plus the DSP48A1 control/data wires
// between the MAC sequencer and its environment (client and slice).
interface dsp48a1_mac_sequencer_if #(
  parameter int unsigned LEN_W = 8
);
  localparam int unsigned OP_W = 18;
  localparam int unsigned P_W  = 48;

  logic             START;
  logic [LEN_W-1:0] LEN;
  logic             BUSY;
  logic             OP_VALID;
  logic             OP_READY;
  logic [OP_W-1:0]  OP_A;
  logic [OP_W-1:0]  OP_B;
  logic [OP_W-1:0]  DSP_A;
  logic [OP_W-1:0]  DSP_B;
  logic [7:0]       DSP_OPMODE;
  logic             DSP_CEA;
  logic             DSP_CEB;
  logic             DSP_CEOPMODE;
  logic             DSP_CEM;
  logic             DSP_CEP;
  logic             DSP_RSTP;
  logic [P_W-1:0]   DSP_P;
  logic             RES_VALID;
  logic             RES_READY;
  logic [P_W-1:0]   RES_DATA;

  // Sequencer side.
  modport slave (
    input  START, LEN, OP_VALID, OP_A, OP_B, DSP_P, RES_READY,
    output BUSY, OP_READY, DSP_A, DSP_B, DSP_OPMODE, DSP_CEA, DSP_CEB,
           DSP_CEOPMODE, DSP_CEM, DSP_CEP, DSP_RSTP, RES_VALID, RES_DATA
  );

  // Client plus slice side.
  modport master (
    output START, LEN, OP_VALID, OP_A, OP_B, DSP_P, RES_READY,
    input  BUSY, OP_READY, DSP_A, DSP_B, DSP_OPMODE, DSP_CEA, DSP_CEB,
           DSP_CEOPMODE, DSP_CEM, DSP_CEP, DSP_RSTP, RES_VALID, RES_DATA
  );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice (A1/B1/M/P/OPMODE registered) as an unsigned
// multiply-accumulate engine and returns the 48-bit dot product of a job.
module dsp48a1_mac_sequencer #(
  parameter int unsigned LEN_W = 8
) (
  input logic                      CLK,
  input logic                      RST_N,
  dsp48a1_mac_sequencer_if.slave   bus
);

  localparam logic [7:0] OPMODE_LOAD = 8'h01;  // P = M
  localparam logic [7:0] OPMODE_ACC  = 8'h09;  // P = P + M

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic             first, first_nxt;
  logic             v1, v2;
  logic             busy_q, op_ready_q, res_valid_q;
  logic [7:0]       opmode_q;
  logic             hs_c;

  assign hs_c = bus.OP_VALID & op_ready_q;

  // Next-state and job bookkeeping.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    first_nxt     = first;
    unique case (state)
      S_IDLE: begin
        if (bus.START) begin
          remaining_nxt = bus.LEN;
          first_nxt     = 1'b1;
          state_nxt     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_nxt = (remaining == LEN_W'(0)) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (hs_c) begin
          remaining_nxt = remaining - LEN_W'(1);
          first_nxt     = 1'b0;
          if (remaining == LEN_W'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Final P load happens on the edge that enters DONE.
        if (!v1 && v2) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.RES_READY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, pipeline flags and registered control outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      remaining   <= '0;
      first       <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      busy_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      opmode_q    <= 8'h00;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      first       <= first_nxt;
      v1          <= hs_c;
      v2          <= v1;
      busy_q      <= (state_nxt != S_IDLE);
      op_ready_q  <= (state_nxt == S_RUN);
      res_valid_q <= (state_nxt == S_DONE);
      opmode_q    <= (hs_c && first) ? OPMODE_LOAD : OPMODE_ACC;
    end
  end

  assign bus.BUSY         = busy_q;
  assign bus.OP_READY     = op_ready_q;
  assign bus.RES_VALID    = res_valid_q;
  assign bus.RES_DATA     = bus.DSP_P;
  assign bus.DSP_A        = bus.OP_A;
  assign bus.DSP_B        = bus.OP_B;
  assign bus.DSP_CEA      = hs_c;
  assign bus.DSP_CEB      = hs_c;
  assign bus.DSP_CEOPMODE = busy_q;
  assign bus.DSP_CEM      = v1;
  assign bus.DSP_CEP      = v2;
  assign bus.DSP_OPMODE   = opmode_q;
  // P is held in reset during RST_N low and cleared once per job.
  assign bus.DSP_RSTP     = ~RST_N | (state == S_CLEAR);

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: behavioural DSP48A1 slice beside the DUT,
// expected results from plain sum-of-products arithmetic.
module tb_dsp48a1_mac_sequencer;

  localparam int unsigned LEN_W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [17:0] qa [256];
  logic [17:0] qb [256];

  dsp48a1_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

  dsp48a1_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice with A1REG=B1REG=MREG=PREG=OPMODEREG=1; X=M when OPMODE[1:0]=01, Z=P when OPMODE[3:2]=10.
  logic [17:0] sl_a1, sl_b1;
  logic [35:0] sl_m;
  logic [7:0]  sl_op;
  logic [47:0] sl_p;

  always @(posedge clk) begin
    if (bus.DSP_CEA) sl_a1 <= bus.DSP_A;
    if (bus.DSP_CEB) sl_b1 <= bus.DSP_B;
    if (bus.DSP_CEM) sl_m <= sl_a1 * sl_b1;
    if (bus.DSP_CEOPMODE) sl_op <= bus.DSP_OPMODE;
    if (bus.DSP_RSTP) sl_p <= '0;
    else if (bus.DSP_CEP)
      sl_p <= ((sl_op[3:2] == 2'b10) ? sl_p : 48'd0) +
              ((sl_op[1:0] == 2'b01) ? 48'(sl_m) : 48'd0);
  end

  assign bus.DSP_P = sl_p;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     48'(bus.BUSY), 48'd0);
    check({tag, "_op_ready"}, 48'(bus.OP_READY), 48'd0);
    check({tag, "_res_valid"},48'(bus.RES_VALID), 48'd0);
    check({tag, "_ce"},       48'({bus.DSP_CEA, bus.DSP_CEB, bus.DSP_CEM, bus.DSP_CEP, bus.DSP_CEOPMODE}), 48'd0);
    check({tag, "_opmode"},   48'(bus.DSP_OPMODE), 48'h00);
  endtask

  // gap>=0: idle cycles after each accepted pair; gap<0: random 30% stalls.
  task automatic run_job(input int len, input int gap, input int hold,
                         input bit start_noise, input int abort_at);
    logic [47:0] exp;
    int j, idx, last_j, wait_cnt, budget;
    int cea_n, cem_n, cep_n, rstp_n, opr_n;
    bit present, hs;
    logic [47:0] held;

    exp = '0;
    for (int i = 0; i < len; i++) exp = exp + (48'(qa[i]) * 48'(qb[i]));

    @(negedge clk);
    bus.START = 1'b1;
    bus.LEN   = LEN_W'(len);
    @(negedge clk);
    bus.START = 1'b0;
    j = 0; idx = 0; last_j = -2; wait_cnt = 0;
    cea_n = 0; cem_n = 0; cep_n = 0; rstp_n = 0; opr_n = 0;
    budget = 60 + len * ((gap > 0 ? gap : 3) + 2);

    while (!bus.RES_VALID && j < budget) begin
      if (abort_at >= 0 && idx == abort_at) begin
        bus.OP_VALID = 1'b0;
        bus.START    = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rstp_during_reset", 48'(bus.DSP_RSTP), 48'd1);
        @(negedge clk);
        check_reset_outputs("abort");
        check("abort_p_cleared", sl_p, 48'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_result", 48'(bus.RES_VALID), 48'd0);
        check("abort_idle", 48'(bus.BUSY), 48'd0);
        return;
      end
      if (bus.DSP_CEM)  cem_n++;
      if (bus.DSP_RSTP) rstp_n++;
      if (bus.OP_READY) opr_n++;
      if (bus.DSP_CEP) begin
        cep_n++;
        check("opmode_before_cep", 48'(sl_op), (cep_n == 1) ? 48'h01 : 48'h09);
      end
      present = (idx < len) && ((gap >= 0) ? (wait_cnt == 0) : ($urandom_range(99) >= 30));
      bus.OP_VALID = present;
      bus.OP_A     = present ? qa[idx] : 18'($urandom);
      bus.OP_B     = present ? qb[idx] : 18'($urandom);
      if (start_noise) bus.START = 1'($urandom_range(1));
      #1;
      hs = bus.OP_VALID && bus.OP_READY;
      if (bus.DSP_CEA) cea_n++;
      if (hs) begin
        idx++;
        last_j = j;
      end
      if (gap >= 0) begin
        if (hs) wait_cnt = gap;
        else if (wait_cnt > 0) wait_cnt--;
      end
      @(negedge clk);
      j++;
    end
    bus.OP_VALID = 1'b0;
    bus.START    = 1'b0;

    check("res_valid_timeout", 48'(bus.RES_VALID), 48'd1);
    check("res_data", bus.RES_DATA, exp);
    check("latency", 48'(j), (len == 0) ? 48'd1 : 48'(last_j + 3));
    check("cea_pulses", 48'(cea_n), 48'(len));
    check("cem_pulses", 48'(cem_n), 48'(len));
    check("cep_pulses", 48'(cep_n), 48'(len));
    check("rstp_pulses", 48'(rstp_n), 48'd1);
    if (len == 0) check("op_ready_len0", 48'(opr_n), 48'd0);

    held = bus.RES_DATA;
    for (int h = 0; h < hold; h++) begin
      if (start_noise) bus.START = 1'b1;
      check("done_hold_data", bus.RES_DATA, exp);
      check("done_hold_cep", 48'({bus.DSP_CEP, bus.RES_VALID}), 48'd1);
      @(negedge clk);
    end
    check("done_stable", bus.RES_DATA, held);
    bus.RES_READY = 1'b1;
    @(negedge clk);
    bus.RES_READY = 1'b0;
    bus.START     = 1'b0;
    check("idle_after_ready", 48'({bus.BUSY, bus.RES_VALID}), 48'd0);
    @(negedge clk);
    check("no_second_job", 48'(bus.BUSY), 48'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n         = 1'b0;
    bus.START     = 1'b0;
    bus.LEN       = '0;
    bus.OP_VALID  = 1'b0;
    bus.OP_A      = '0;
    bus.OP_B      = '0;
    bus.RES_READY = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_rstp", 48'(bus.DSP_RSTP), 48'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_rstp", 48'(bus.DSP_RSTP), 48'd0);

    for (int i = 0; i < 4; i++) begin qa[i] = 18'(i + 1); qb[i] = 18'd10; end
    run_job(4, 0, 0, 1'b0, -1);
    run_job(4, 3, 0, 1'b0, -1);
    run_job(0, 0, 2, 1'b0, -1);

    for (int i = 0; i < 255; i++) begin qa[i] = 18'h3FFFF; qb[i] = 18'h3FFFF; end
    run_job(255, 0, 0, 1'b0, -1);
    check("len255_value", bus.RES_DATA, 48'd17523332874495);

    for (int i = 0; i < 8; i++) begin qa[i] = 18'($urandom); qb[i] = 18'($urandom); end
    run_job(8, 0, 0, 1'b0, 5);
    qa[0] = 18'd3; qb[0] = 18'd5; qa[1] = 18'd7; qb[1] = 18'd1;
    run_job(2, 0, 0, 1'b0, -1);

    for (int i = 0; i < 5; i++) begin qa[i] = 18'($urandom); qb[i] = 18'($urandom); end
    run_job(5, -1, 10, 1'b1, -1);

    for (int t = 0; t < 25; t++) begin
      int len;
      len = int'($urandom_range(40));
      for (int i = 0; i < len; i++) begin
        qa[i] = ($urandom_range(3) == 0) ? 18'h3FFFF : 18'($urandom);
        qb[i] = ($urandom_range(3) == 0) ? 18'h3FFFF : 18'($urandom);
      end
      run_job(len, ($urandom_range(1) == 1) ? -1 : int'($urandom_range(2)),
              int'($urandom_range(3)), 1'($urandom_range(1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
